// File: rtl/debug_trace_buf_pkg.sv
// -----------------------------------------------------------------------------
// debug_trace_buf_pkg
//   Shared types for the retire-trace capture buffer: the capture FSM state
//   encoding and the trace entry record. Depth-dependent widths are kept local
//   to the modules that need them.
// -----------------------------------------------------------------------------
package debug_trace_buf_pkg;

    localparam int unsigned STAMP_W = 16;
    localparam int unsigned PIPE_W  = 2;   // enough for up to four pipes

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } trc_state_e;

    typedef struct packed {
        logic [PIPE_W-1:0]  pipe;
        logic [STAMP_W-1:0] stamp;
        logic [31:0]        pc;
        logic [4:0]         rd;
        logic [31:0]        data;
    } trace_ent_t;

    localparam int unsigned ENT_W = $bits(trace_ent_t);

endpackage

// File: rtl/debug_trace_buf_compact.sv
// -----------------------------------------------------------------------------
// trace_compact
//   Combinational lane packer. Valid retire lanes are packed, in ascending pipe
//   index, into the low slots of ents_o; n_o reports how many slots are used.
// Ports
//   stamp_i    cycle stamp attached to every entry built this cycle
//   valid_i    per-pipe retire valid
//   pc_i       per-pipe PC, flattened (pipe p at [p*32 +: 32])
//   rd_i       per-pipe destination register, flattened (pipe p at [p*5 +: 5])
//   data_i     per-pipe writeback data, flattened (pipe p at [p*32 +: 32])
//   ents_o     packed entries, slot k at [k*ENT_W +: ENT_W]; unused slots zero
//   n_o        number of valid lanes (0..S_PIPE_CNT)
// -----------------------------------------------------------------------------
module trace_compact
    import debug_trace_buf_pkg::*;
#(
    parameter int unsigned S_PIPE_CNT = 3
) (
    input  logic [STAMP_W-1:0]               stamp_i,
    input  logic [S_PIPE_CNT-1:0]            valid_i,
    input  logic [S_PIPE_CNT*32-1:0]         pc_i,
    input  logic [S_PIPE_CNT*5-1:0]          rd_i,
    input  logic [S_PIPE_CNT*32-1:0]         data_i,
    output logic [S_PIPE_CNT*ENT_W-1:0]      ents_o,
    output logic [$clog2(S_PIPE_CNT+1)-1:0]  n_o
);

    localparam int unsigned CNT_W = $clog2(S_PIPE_CNT + 1);

    trace_ent_t lane_ent_s;
    int unsigned slot_s;

    // Walk the lanes in pipe order, dropping each valid one into the next free slot.
    always_comb begin
        ents_o     = '0;
        lane_ent_s = '0;
        slot_s     = 0;
        for (int p = 0; p < int'(S_PIPE_CNT); p++) begin
            if (valid_i[p]) begin
                lane_ent_s.pipe  = PIPE_W'(p);
                lane_ent_s.stamp = stamp_i;
                lane_ent_s.pc    = pc_i[p*32 +: 32];
                lane_ent_s.rd    = rd_i[p*5 +: 5];
                lane_ent_s.data  = data_i[p*32 +: 32];
                ents_o[slot_s*ENT_W +: ENT_W] = lane_ent_s;
                slot_s = slot_s + 1;
            end else begin
                slot_s = slot_s;
            end
        end
        n_o = CNT_W'(slot_s);
    end

endmodule

// File: rtl/debug_trace_buf.sv
// -----------------------------------------------------------------------------
// debug_trace_buf
//   Circular retire-trace history. Captures packed retire records while ARMED or
//   POST, freezes STOP_CYCLES enabled cycles after the trigger, raises halt_req
//   while frozen and drains oldest-first over a valid/ready port.
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   en_i             capture / stamp / countdown enable
//   arm_i            clear buffer and start capture (wins over everything)
//   trig_i           trigger event (acts in ARMED only)
//   wb_valid_i       per-pipe retire valid
//   wb_pc_i/rd_i/data_i  per-pipe retire record, flattened per pipe
//   halt_req_o       high while FROZEN
//   state_o          0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
//   fill_o           valid entries held
//   rd_valid_o       drain entry available
//   rd_ready_i       drain consumer accepts
//   rd_ent_o         oldest entry
// -----------------------------------------------------------------------------
module debug_trace_buf
    import debug_trace_buf_pkg::*;
#(
    parameter int unsigned S_PIPE_CNT  = 3,
    parameter int unsigned STOP_CYCLES = 1,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        arm_i,
    input  logic                        trig_i,
    input  logic [S_PIPE_CNT-1:0]       wb_valid_i,
    input  logic [S_PIPE_CNT*32-1:0]    wb_pc_i,
    input  logic [S_PIPE_CNT*5-1:0]     wb_rd_i,
    input  logic [S_PIPE_CNT*32-1:0]    wb_data_i,
    output logic                        halt_req_o,
    output logic [1:0]                  state_o,
    output logic [$clog2(DEPTH):0]      fill_o,
    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output trace_ent_t                  rd_ent_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned SUM_W  = FILL_W + 1;
    localparam int unsigned CNT_W  = $clog2(S_PIPE_CNT + 1);

    trc_state_e               state_q, state_d;
    logic [7:0]               post_cnt_q, post_cnt_d;
    logic [STAMP_W-1:0]       stamp_q, stamp_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    trace_ent_t               mem_q [DEPTH];

    logic [S_PIPE_CNT*ENT_W-1:0] ents_s;
    logic [CNT_W-1:0]            n_s;
    logic                        capturing_s;
    logic                        cap_s;
    logic                        rd_valid_s;
    logic                        pop_s;
    logic [SUM_W-1:0]            sum_s;

    trace_compact #(
        .S_PIPE_CNT (S_PIPE_CNT)
    ) u_compact (
        .stamp_i (stamp_q),
        .valid_i (wb_valid_i),
        .pc_i    (wb_pc_i),
        .rd_i    (wb_rd_i),
        .data_i  (wb_data_i),
        .ents_o  (ents_s),
        .n_o     (n_s)
    );

    // Qualifiers shared by the datapath: capture window, drain handshake.
    always_comb begin
        capturing_s = (state_q == ST_ARMED) || (state_q == ST_POST);
        cap_s       = en_i && !arm_i && capturing_s;
        rd_valid_s  = (state_q == ST_FROZEN) && (fill_q != '0);
        pop_s       = rd_valid_s && rd_ready_i && !arm_i;
        sum_s       = SUM_W'(fill_q) + SUM_W'(n_s);
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; arm overrides any trigger or drain activity.
    always_comb begin
        state_d = state_q;
        if (arm_i) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMED: begin
                    if (trig_i && en_i) begin
                        state_d = (STOP_CYCLES == 0) ? ST_FROZEN : ST_POST;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (en_i && (post_cnt_q == 8'd1)) begin
                        state_d = ST_FROZEN;
                    end else begin
                        state_d = ST_POST;
                    end
                end
                ST_FROZEN: begin
                    if (fill_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FROZEN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs, all decoded from registered state only.
    always_comb begin
        state_o    = state_q;
        halt_req_o = (state_q == ST_FROZEN);
        fill_o     = fill_q;
        rd_valid_o = rd_valid_s;
        rd_ent_o   = mem_q[rd_ptr_q];
    end

    // Post-trigger countdown and cycle stamp next-state.
    always_comb begin
        post_cnt_d = post_cnt_q;
        if (arm_i) begin
            post_cnt_d = 8'd0;
        end else if ((state_q == ST_ARMED) && trig_i && en_i) begin
            post_cnt_d = 8'(STOP_CYCLES);
        end else if ((state_q == ST_POST) && en_i) begin
            post_cnt_d = post_cnt_q - 8'd1;
        end else begin
            post_cnt_d = post_cnt_q;
        end

        if (en_i && capturing_s) begin
            stamp_d = stamp_q + 16'd1;
        end else begin
            stamp_d = stamp_q;
        end
    end

    // Pointer / fill next-state. On overflow the read pointer is pushed
    // forward by the excess so the newest DEPTH entries survive.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (arm_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else if (cap_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(n_s);
            if (sum_s > SUM_W'(DEPTH)) begin
                fill_d   = FILL_W'(DEPTH);
                rd_ptr_d = rd_ptr_q + PTR_W'(sum_s - SUM_W'(DEPTH));
            end else begin
                fill_d   = sum_s[FILL_W-1:0];
                rd_ptr_d = rd_ptr_q;
            end
        end else if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            fill_d   = fill_q - FILL_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            post_cnt_q <= 8'd0;
            stamp_q    <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
        end else begin
            post_cnt_q <= post_cnt_d;
            stamp_q    <= stamp_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
        end
    end

    // Entry storage: packed slots land at consecutive addresses from wr_ptr.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (cap_s) begin
            for (int k = 0; k < int'(S_PIPE_CNT); k++) begin
                if (k < int'(n_s)) begin
                    mem_q[wr_ptr_q + PTR_W'(k)] <= ents_s[k*ENT_W +: ENT_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_trace_buf.sv
module tb_debug_trace_buf;
    import debug_trace_buf_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, arm, trig, rd_ready;
    logic [2:0]  wb_valid;
    logic [95:0] wb_pc;
    logic [14:0] wb_rd;
    logic [95:0] wb_data;

    logic        halt,  halt_z;
    logic [1:0]  state, state_z;
    logic [4:0]  fill,  fill_z;
    logic        rd_valid, rd_valid_z;
    trace_ent_t  rd_ent, rd_ent_z;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    debug_trace_buf #(.S_PIPE_CNT(3), .STOP_CYCLES(1), .DEPTH(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .arm_i(arm), .trig_i(trig),
        .wb_valid_i(wb_valid), .wb_pc_i(wb_pc), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .halt_req_o(halt), .state_o(state), .fill_o(fill), .rd_valid_o(rd_valid),
        .rd_ready_i(rd_ready), .rd_ent_o(rd_ent)
    );

    debug_trace_buf #(.S_PIPE_CNT(3), .STOP_CYCLES(0), .DEPTH(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .arm_i(arm), .trig_i(trig),
        .wb_valid_i(wb_valid), .wb_pc_i(wb_pc), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .halt_req_o(halt_z), .state_o(state_z), .fill_o(fill_z), .rd_valid_o(rd_valid_z),
        .rd_ready_i(rd_ready), .rd_ent_o(rd_ent_z)
    );

    function automatic logic [31:0] lane_pc(input int cyc, input int p);
        return 32'h8000_0000 | (32'(cyc) << 8) | (32'(p) << 2);
    endfunction

    function automatic logic [4:0] lane_rd(input int cyc, input int p);
        return 5'(cyc + p);
    endfunction

    function automatic logic [31:0] lane_data(input int cyc, input int p);
        return {16'(cyc), 8'hA5, 8'(p)};
    endfunction

    function automatic trace_ent_t mk(input int p, input int stamp, input int cyc);
        trace_ent_t e;
        e.pipe  = 2'(p);
        e.stamp = 16'(stamp);
        e.pc    = lane_pc(cyc, p);
        e.rd    = lane_rd(cyc, p);
        e.data  = lane_data(cyc, p);
        return e;
    endfunction

    task automatic set_lanes(input int cyc, input logic [2:0] m);
        wb_valid = m;
        for (int p = 0; p < 3; p++) begin
            wb_pc[p*32 +: 32]   = lane_pc(cyc, p);
            wb_rd[p*5 +: 5]     = lane_rd(cyc, p);
            wb_data[p*32 +: 32] = lane_data(cyc, p);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int exp_pipe [9] = '{0, 1, 2, 0, 1, 2, 0, 2, 1};
    int exp_cyc  [9] = '{1, 1, 1, 2, 2, 2, 3, 3, 4};

    initial begin
        rst = 1'b1; en = 1'b0; arm = 1'b0; trig = 1'b0; rd_ready = 1'b0;
        set_lanes(0, 3'b111);

        // 1. reset
        tick(); tick();
        chk("rst_state", 128'(state), 128'(2'd0));
        chk("rst_fill", 128'(fill), 128'(5'd0));
        chk("rst_rd_valid", 128'(rd_valid), 128'(1'b0));
        chk("rst_halt", 128'(halt), 128'(1'b0));
        chk("rst_ent", 128'(rd_ent), 128'(0));
        rst = 1'b0; en = 1'b1;

        // 2. basic capture, trigger, post cycle, drain order
        arm = 1'b1; tick(); arm = 1'b0;
        chk("t2_armed", 128'(state), 128'(2'd1));
        chk("t2_fill0", 128'(fill), 128'(5'd0));
        set_lanes(1, 3'b111); tick();
        chk("t2_fill3", 128'(fill), 128'(5'd3));
        set_lanes(2, 3'b111); tick();
        chk("t2_fill6", 128'(fill), 128'(5'd6));
        set_lanes(3, 3'b101); trig = 1'b1; tick(); trig = 1'b0;
        chk("t2_post", 128'(state), 128'(2'd2));
        chk("t2_fill8", 128'(fill), 128'(5'd8));
        set_lanes(4, 3'b010); tick();
        chk("t2_frozen", 128'(state), 128'(2'd3));
        chk("t2_halt", 128'(halt), 128'(1'b1));
        chk("t2_fill9", 128'(fill), 128'(5'd9));
        chk("t2_rd_valid", 128'(rd_valid), 128'(1'b1));
        set_lanes(0, 3'b000);
        for (int i = 0; i < 9; i++) begin
            chk("t2_drain", 128'(rd_ent), 128'(mk(exp_pipe[i], exp_cyc[i] - 1, exp_cyc[i])));
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        chk("t2_empty", 128'(fill), 128'(5'd0));
        chk("t2_still_frozen", 128'(state), 128'(2'd3));
        tick();
        chk("t2_idle", 128'(state), 128'(2'd0));
        chk("t2_halt_drop", 128'(halt), 128'(1'b0));

        // 3. overflow: 21 entries into 16 slots, stamps 4..10
        arm = 1'b1; tick(); arm = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            set_lanes(10 + c, 3'b111); tick();
        end
        set_lanes(0, 3'b000); trig = 1'b1; tick(); trig = 1'b0;
        tick();
        chk("t3_frozen", 128'(state), 128'(2'd3));
        chk("t3_fill16", 128'(fill), 128'(5'd16));
        for (int k = 5; k < 21; k++) begin
            chk("t3_drain", 128'(rd_ent), 128'(mk(k % 3, 4 + k / 3, 10 + k / 3 + 1)));
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        chk("t3_empty", 128'(fill), 128'(5'd0));
        tick();
        chk("t3_idle", 128'(state), 128'(2'd0));

        // 4. arm+trig together, then stop_cycles=0 instance
        arm = 1'b1; trig = 1'b1; tick(); arm = 1'b0;
        chk("t4_armed", 128'(state), 128'(2'd1));
        chk("t4_armed_z", 128'(state_z), 128'(2'd1));
        tick(); trig = 1'b0;
        chk("t4_post", 128'(state), 128'(2'd2));
        chk("t4_frozen_z", 128'(state_z), 128'(2'd3));
        chk("t4_halt_z", 128'(halt_z), 128'(1'b1));
        tick();
        chk("t4_frozen", 128'(state), 128'(2'd3));
        chk("t4_idle_z", 128'(state_z), 128'(2'd0));
        tick();
        chk("t4_idle", 128'(state), 128'(2'd0));

        // 5. drain with rd_ready 1,0,1 (stamp now 15)
        arm = 1'b1; tick(); arm = 1'b0;
        set_lanes(30, 3'b011); trig = 1'b1; tick(); trig = 1'b0;
        set_lanes(0, 3'b000); tick();
        chk("t5_frozen", 128'(state), 128'(2'd3));
        chk("t5_fill2", 128'(fill), 128'(5'd2));
        chk("t5_ent0", 128'(rd_ent), 128'(mk(0, 15, 30)));
        rd_ready = 1'b1; tick();
        chk("t5_fill1", 128'(fill), 128'(5'd1));
        chk("t5_ent1", 128'(rd_ent), 128'(mk(1, 15, 30)));
        rd_ready = 1'b0; tick();
        chk("t5_hold_fill", 128'(fill), 128'(5'd1));
        chk("t5_hold_ent", 128'(rd_ent), 128'(mk(1, 15, 30)));
        chk("t5_hold_valid", 128'(rd_valid), 128'(1'b1));
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        chk("t5_empty", 128'(fill), 128'(5'd0));
        chk("t5_still_halt", 128'(halt), 128'(1'b1));
        chk("t5_no_valid", 128'(rd_valid), 128'(1'b0));
        tick();
        chk("t5_idle", 128'(state), 128'(2'd0));
        chk("t5_halt_drop", 128'(halt), 128'(1'b0));

        // 6. en=0 holds POST, then reset mid-drain (stamp now 17)
        arm = 1'b1; tick(); arm = 1'b0;
        set_lanes(40, 3'b001); trig = 1'b1; tick(); trig = 1'b0;
        en = 1'b0; set_lanes(41, 3'b111);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_state", 128'(state), 128'(2'd2));
            chk("t6_hold_fill", 128'(fill), 128'(5'd1));
        end
        en = 1'b1; set_lanes(42, 3'b100); tick();
        set_lanes(0, 3'b000);
        chk("t6_frozen", 128'(state), 128'(2'd3));
        chk("t6_fill2", 128'(fill), 128'(5'd2));
        chk("t6_ent0", 128'(rd_ent), 128'(mk(0, 17, 40)));
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        chk("t6_ent1", 128'(rd_ent), 128'(mk(2, 18, 42)));
        chk("t6_fill1", 128'(fill), 128'(5'd1));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_state", 128'(state), 128'(2'd0));
        chk("t6_rst_fill", 128'(fill), 128'(5'd0));
        chk("t6_rst_valid", 128'(rd_valid), 128'(1'b0));
        chk("t6_rst_halt", 128'(halt), 128'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
